// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V IF stage with PC, IF/ID register, stall/redirect/halt; FETCH_PERF_CNT_EN adds fetch/flush counters
module fetch_stage #(
  parameter int INS_ADDRESS = 32,
  parameter int INS_W = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC = '0,
  parameter logic [INS_ADDRESS-1:0] MAX_PC = INS_ADDRESS'(70),
  parameter logic [INS_W-1:0] NOP = INS_W'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [INS_ADDRESS-1:0] redirect_pc_i,
  output logic [INS_ADDRESS-1:0] imem_addr_o,
  input  logic [INS_W-1:0]       imem_instr_i,
  output logic                   ifid_valid_o,
  output logic [INS_ADDRESS-1:0] ifid_pc_o,
  output logic [INS_ADDRESS-1:0] ifid_pc4_o,
  output logic [INS_W-1:0]       ifid_instr_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]            fetch_cnt_o,
  output logic [31:0]            flush_cnt_o,
`endif
  output logic                   halted_o
);
  logic [INS_ADDRESS-1:0] pc, pc4;
  logic halt, load;
  assign imem_addr_o = pc;
  assign pc4 = pc + INS_ADDRESS'(4);
  // halting takes effect on the very edge that sees pc beyond MAX_PC
  assign halt = halted_o | (pc > MAX_PC);
  assign load = !redirect_i && !halt && !stall_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      ifid_valid_o <= 1'b0;
      ifid_pc_o <= '0;
      ifid_pc4_o <= '0;
      ifid_instr_o <= NOP;
      halted_o <= 1'b0;
    end else if (redirect_i) begin
      pc <= redirect_pc_i;
      ifid_valid_o <= 1'b0;
      ifid_pc_o <= '0;
      ifid_pc4_o <= '0;
      ifid_instr_o <= NOP;
      halted_o <= halted_o & (redirect_pc_i > MAX_PC);
    end else if (halt) begin
      halted_o <= 1'b1;
      ifid_valid_o <= 1'b0;
      ifid_pc_o <= '0;
      ifid_pc4_o <= '0;
      ifid_instr_o <= NOP;
    end else if (load) begin
      pc <= pc4;
      ifid_valid_o <= 1'b1;
      ifid_pc_o <= pc;
      ifid_pc4_o <= pc4;
      ifid_instr_o <= imem_instr_i;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (load && fetch_cnt_o != '1) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (redirect_i && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; define FETCH_PERF_CNT_EN to also check counters
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int MAXPC = 70;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0, imem_addr, imem_instr, ifid_pc, ifid_pc4, ifid_instr;
  logic ifid_valid, halted;
  logic [31:0] fetch_cnt, flush_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    logic v;
    logic h;
    logic [31:0] addr, pc, pc4, instr, fc, rc;
  } exp_t;
  exp_t q[$];
  logic [31:0] mpc, mifpc, mifpc4, minstr, mfc, mrc;
  logic mv, mh;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  assign imem_instr = mem(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .ifid_valid_o(ifid_valid), .ifid_pc_o(ifid_pc), .ifid_pc4_o(ifid_pc4),
    .ifid_instr_o(ifid_instr),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o(fetch_cnt), .flush_cnt_o(flush_cnt),
`endif
    .halted_o(halted));
`ifndef FETCH_PERF_CNT_EN
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void push();
    exp_t e;
    e.v = mv; e.h = mh; e.addr = mpc; e.pc = mifpc; e.pc4 = mifpc4;
    e.instr = minstr; e.fc = mfc; e.rc = mrc;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    mpc = '0; mv = 0; mifpc = '0; mifpc4 = '0; minstr = NOP; mh = 0; mfc = '0; mrc = '0;
  endfunction

  function automatic void bubble();
    mv = 0; mifpc = '0; mifpc4 = '0; minstr = NOP;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr", imem_addr, e.addr);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
      chk("ifid_pc", ifid_pc, e.pc);
      chk("ifid_pc4", ifid_pc4, e.pc4);
      chk("ifid_instr", ifid_instr, e.instr);
      chk("halted", {31'd0, halted}, {31'd0, e.h});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, e.fc);
      chk("flush_cnt", flush_cnt, e.rc);
`endif
    end
  end

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    #1;
    rst_n = 1'b1; stall = s; redirect = r; redirect_pc = t;
    if (r) begin
      mpc = t;
      bubble();
      mh = mh && (t > MAXPC);
      if (mrc != '1) mrc++;
    end else if (mh || mpc > MAXPC) begin
      mh = 1;
      bubble();
    end else if (!s) begin
      mv = 1; mifpc = mpc; mifpc4 = mpc + 4; minstr = mem(mpc); mpc = mpc + 4;
      if (mfc != '1) mfc++;
    end
    push();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0; stall = 0; redirect = 0;
    model_reset();
    #1;
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    push();
  endtask

  initial begin
    model_reset();
    do_reset();
    repeat (3) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    while (mpc != 28) step(0, 0, 0);
    step(0, 1, 30);
    step(0, 0, 0);
    step(1, 1, 8);
    step(0, 0, 0);
    while (mpc != 72) step(0, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 76);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (2) step(0, 0, 0);
    do_reset();
    repeat (5) step(0, 0, 0);
    step(0, 1, 40);
    @(negedge clk);
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("cnt5_fetch", fetch_cnt, 32'd5);
    chk("cnt5_flush", flush_cnt, 32'd1);
`endif
    step(0, 0, 0);
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step($urandom_range(3) == 0, $urandom_range(11) == 0, $urandom_range(84));
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
